multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS-subset datapath.
- Sits directly upstream of the ALU control decoder: it produces the 2-bit ALU_op consumed there, plus all datapath mux selects and write enables.
- Sequences fetch / decode / execute / memory / writeback per instruction.
- Stalls on a memory ready handshake.

---
 rtl/multicycle_control.sv | 154 +++++++++++++++
 tb/tb_multicycle_control.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset datapath: sequences each
// instruction through fetch/decode/execute/memory/writeback, stalling on mem_ready.
module multicycle_control #(
  parameter int OPCODE_SIZE = 6,
  parameter int ALU_OP_SIZE = 2,
  parameter int STATE_SIZE  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OPCODE_SIZE-1:0] opcode,
  input  logic                   mem_ready,
  output logic                   PC_write,
  output logic                   PC_write_cond,
  output logic                   IorD,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   IR_write,
  output logic                   mem_to_reg,
  output logic                   reg_dst,
  output logic                   reg_write,
  output logic                   ALU_src_A,
  output logic [1:0]             ALU_src_B,
  output logic [ALU_OP_SIZE-1:0] ALU_op,
  output logic [1:0]             PC_source,
  output logic                   illegal_op,
  output logic [STATE_SIZE-1:0]  state
);

  typedef enum logic [STATE_SIZE-1:0] {
    FETCH     = STATE_SIZE'(0),
    DECODE    = STATE_SIZE'(1),
    MEM_ADDR  = STATE_SIZE'(2),
    MEM_READ  = STATE_SIZE'(3),
    MEM_WB    = STATE_SIZE'(4),
    MEM_WRITE = STATE_SIZE'(5),
    R_EXEC    = STATE_SIZE'(6),
    R_WB      = STATE_SIZE'(7),
    BRANCH    = STATE_SIZE'(8),
    JUMP      = STATE_SIZE'(9),
    ADDI_EXEC = STATE_SIZE'(10),
    ADDI_WB   = STATE_SIZE'(11)
  } state_t;

  localparam logic [OPCODE_SIZE-1:0] OP_RTYPE = OPCODE_SIZE'(0);
  localparam logic [OPCODE_SIZE-1:0] OP_J     = OPCODE_SIZE'(2);
  localparam logic [OPCODE_SIZE-1:0] OP_BEQ   = OPCODE_SIZE'(4);
  localparam logic [OPCODE_SIZE-1:0] OP_ADDI  = OPCODE_SIZE'(8);
  localparam logic [OPCODE_SIZE-1:0] OP_LUI   = OPCODE_SIZE'(15);
  localparam logic [OPCODE_SIZE-1:0] OP_LW    = OPCODE_SIZE'(35);
  localparam logic [OPCODE_SIZE-1:0] OP_SW    = OPCODE_SIZE'(43);

  localparam logic [ALU_OP_SIZE-1:0] ALU_ADD   = ALU_OP_SIZE'(0);
  localparam logic [ALU_OP_SIZE-1:0] ALU_SUB   = ALU_OP_SIZE'(1);
  localparam logic [ALU_OP_SIZE-1:0] ALU_FUNCT = ALU_OP_SIZE'(2);

  state_t state_q;

  assign state = state_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      illegal_op <= 1'b0;
    end else begin
      case (state_q)
        FETCH:     if (mem_ready) state_q <= DECODE;
        DECODE: begin
          case (opcode)
            OP_RTYPE, OP_LUI: state_q <= R_EXEC;
            OP_LW, OP_SW:     state_q <= MEM_ADDR;
            OP_BEQ:           state_q <= BRANCH;
            OP_J:             state_q <= JUMP;
            OP_ADDI:          state_q <= ADDI_EXEC;
            default: begin
              state_q    <= FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        end
        MEM_ADDR:  state_q <= (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
        MEM_READ:  if (mem_ready) state_q <= MEM_WB;
        MEM_WRITE: if (mem_ready) state_q <= FETCH;
        R_EXEC:    state_q <= R_WB;
        ADDI_EXEC: state_q <= ADDI_WB;
        default:   state_q <= FETCH;  // writebacks, branch, jump, unused codes
      endcase
    end
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    PC_write      = 1'b0;
    PC_write_cond = 1'b0;
    IorD          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    IR_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    ALU_src_A     = 1'b0;
    ALU_src_B     = 2'b00;
    ALU_op        = ALU_ADD;
    PC_source     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        ALU_src_B = 2'b01;
        // Load PC/IR only on the completing cycle so a stall never double-loads.
        IR_write  = mem_ready;
        PC_write  = mem_ready;
      end
      DECODE:    ALU_src_B = 2'b11;
      MEM_ADDR, ADDI_EXEC: begin
        ALU_src_A = 1'b1;
        ALU_src_B = 2'b10;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      R_EXEC: begin
        ALU_src_A = 1'b1;
        ALU_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      BRANCH: begin
        ALU_src_A     = 1'b1;
        ALU_op        = ALU_SUB;
        PC_write_cond = 1'b1;
        PC_source     = 2'b01;
      end
      JUMP: begin
        PC_write  = 1'b1;
        PC_source = 2'b10;
      end
      ADDI_WB:   reg_write = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a per-cycle vector table with hand-coded
// expected state/controls, then instruction-length and mid-instruction reset sequences.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write;
  logic       mem_to_reg, reg_dst, reg_write, ALU_src_A;
  logic [1:0] ALU_src_B, ALU_op, PC_source;
  logic       illegal_op;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PC_write(PC_write), .PC_write_cond(PC_write_cond), .IorD(IorD),
    .mem_read(mem_read), .mem_write(mem_write), .IR_write(IR_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .ALU_src_A(ALU_src_A), .ALU_src_B(ALU_src_B), .ALU_op(ALU_op),
    .PC_source(PC_source), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  // Packed controls: {PCw,PCwc,IorD,mr | mw,IRw,m2r,rdst | rw,srcA,srcB[1:0] | op[1:0],ps[1:0]}
  logic [15:0] ctrl;
  assign ctrl = {PC_write, PC_write_cond, IorD, mem_read, mem_write, IR_write,
                 mem_to_reg, reg_dst, reg_write, ALU_src_A, ALU_src_B, ALU_op, PC_source};

  localparam logic [15:0] C_FETCH_GO   = 16'h9410;
  localparam logic [15:0] C_FETCH_WAIT = 16'h1010;
  localparam logic [15:0] C_DECODE     = 16'h0030;
  localparam logic [15:0] C_ADDR       = 16'h0060;  // MEM_ADDR and ADDI_EXEC
  localparam logic [15:0] C_MEM_READ   = 16'h3000;
  localparam logic [15:0] C_MEM_WB     = 16'h0280;
  localparam logic [15:0] C_MEM_WRITE  = 16'h2800;
  localparam logic [15:0] C_R_EXEC     = 16'h0048;
  localparam logic [15:0] C_R_WB       = 16'h0180;
  localparam logic [15:0] C_BRANCH     = 16'h4045;
  localparam logic [15:0] C_JUMP       = 16'h8002;
  localparam logic [15:0] C_ADDI_WB    = 16'h0080;

  typedef struct {
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic [3:0]  exp_state;
    logic [15:0] exp_ctrl;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t v(logic r, logic [5:0] op, logic rdy,
                             logic [3:0] st, logic [15:0] c, logic ill);
    vec_t x;
    x.rst = r; x.opcode = op; x.mem_ready = rdy;
    x.exp_state = st; x.exp_ctrl = c; x.exp_ill = ill;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Precondition and postcondition: just after a negedge, DUT in FETCH.
  task automatic run_instr(input string name, input logic [5:0] op, input int exp_cycles);
    int n;
    opcode    = op;
    mem_ready = 1'b1;
    n = 1;
    while (n <= 20) begin
      @(negedge clk); #1;
      if (state == 4'd0) break;
      n++;
    end
    check({name, "_cycles"}, n, exp_cycles);
  endtask

  initial begin
    rst = 1'b1; opcode = '0; mem_ready = 1'b0;

    // Inputs per row are applied for that cycle; expectations describe that cycle.
    // R-type
    vecs.push_back(v(0,  0, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0,  0, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0,  0, 1, 6,  C_R_EXEC,     0));
    vecs.push_back(v(0,  0, 1, 7,  C_R_WB,       0));
    // lw with two-cycle stall in MEM_READ
    vecs.push_back(v(0, 35, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0, 35, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0, 35, 1, 2,  C_ADDR,       0));
    vecs.push_back(v(0, 35, 0, 3,  C_MEM_READ,   0));
    vecs.push_back(v(0, 35, 0, 3,  C_MEM_READ,   0));
    vecs.push_back(v(0, 35, 1, 3,  C_MEM_READ,   0));
    vecs.push_back(v(0, 35, 1, 4,  C_MEM_WB,     0));
    // FETCH stall of three cycles, then beq
    vecs.push_back(v(0,  4, 0, 0,  C_FETCH_WAIT, 0));
    vecs.push_back(v(0,  4, 0, 0,  C_FETCH_WAIT, 0));
    vecs.push_back(v(0,  4, 0, 0,  C_FETCH_WAIT, 0));
    vecs.push_back(v(0,  4, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0,  4, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0,  4, 1, 8,  C_BRANCH,     0));
    // j
    vecs.push_back(v(0,  2, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0,  2, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0,  2, 1, 9,  C_JUMP,       0));
    // addi
    vecs.push_back(v(0,  8, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0,  8, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0,  8, 1, 10, C_ADDR,       0));
    vecs.push_back(v(0,  8, 1, 11, C_ADDI_WB,    0));
    // sw with one stall cycle
    vecs.push_back(v(0, 43, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0, 43, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0, 43, 1, 2,  C_ADDR,       0));
    vecs.push_back(v(0, 43, 0, 5,  C_MEM_WRITE,  0));
    vecs.push_back(v(0, 43, 1, 5,  C_MEM_WRITE,  0));
    // lui executes as R-type
    vecs.push_back(v(0, 15, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0, 15, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0, 15, 1, 6,  C_R_EXEC,     0));
    vecs.push_back(v(0, 15, 1, 7,  C_R_WB,       0));
    // illegal opcode 63: sticky through the next instructions
    vecs.push_back(v(0, 63, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0, 63, 1, 1,  C_DECODE,     0));
    vecs.push_back(v(0,  0, 1, 0,  C_FETCH_GO,   1));
    vecs.push_back(v(0,  0, 1, 1,  C_DECODE,     1));
    vecs.push_back(v(0,  0, 1, 6,  C_R_EXEC,     1));
    vecs.push_back(v(0,  0, 1, 7,  C_R_WB,       1));
    // sw, reset while stalled in MEM_WRITE; reset also clears illegal_op
    vecs.push_back(v(0, 43, 1, 0,  C_FETCH_GO,   1));
    vecs.push_back(v(0, 43, 1, 1,  C_DECODE,     1));
    vecs.push_back(v(0, 43, 1, 2,  C_ADDR,       1));
    vecs.push_back(v(1, 43, 0, 5,  C_MEM_WRITE,  1));
    vecs.push_back(v(0,  0, 0, 0,  C_FETCH_WAIT, 0));
    vecs.push_back(v(0,  0, 1, 0,  C_FETCH_GO,   0));
    vecs.push_back(v(0,  0, 1, 1,  C_DECODE,     0));

    // Initial reset: one edge with rst high must land in FETCH with illegal_op clear.
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_state", state, 4'd0);
    check("reset_illegal", illegal_op, 1'b0);
    check("reset_ctrl", ctrl, C_FETCH_GO);

    // The reset cycle above already sits in the first FETCH, so row 0 is checked in place.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      rst       = vecs[i].rst;
      opcode    = vecs[i].opcode;
      mem_ready = vecs[i].mem_ready;
      #1;
      check($sformatf("row%0d_state", i), state,      vecs[i].exp_state);
      check($sformatf("row%0d_ctrl", i),  ctrl,       vecs[i].exp_ctrl);
      check($sformatf("row%0d_ill", i),   illegal_op, vecs[i].exp_ill);
    end

    // Reset back into a known FETCH before the length sequences.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("seq_reset_state", state, 4'd0);

    run_instr("lw",   6'd35, 5);
    run_instr("sw",   6'd43, 4);
    run_instr("rtype", 6'd0, 4);
    run_instr("addi", 6'd8,  4);
    run_instr("lui",  6'd15, 4);
    run_instr("beq",  6'd4,  3);
    run_instr("j",    6'd2,  3);

    // Reset mid-instruction (in R_EXEC) beats the R_EXEC -> R_WB transition.
    opcode = 6'd0; mem_ready = 1'b1;
    @(negedge clk); #1;
    check("midrst_decode", state, 4'd1);
    @(negedge clk); #1;
    check("midrst_rexec", state, 4'd6);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_state", state, 4'd0);
    check("midrst_ctrl", ctrl, C_FETCH_GO);
    run_instr("post_rst_beq", 6'd4, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
